// File: rtl/rx_fifo_pkg.sv
// Shared types and sizing helpers for the RX frame FIFO and its descriptor queue.
package rx_fifo_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } rd_state_t;

    localparam int DROP_CNT_W = 16;

    // Pointer carries one extra MSB so full and empty are distinguishable.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_desc_fifo.sv
// Single-clock 1-bit descriptor FIFO with first-word fall-through read data.
module sync_desc_fifo
    import rx_fifo_pkg::*;
#(
    parameter int pDEPTH = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic pop,
    input  logic din,
    output logic dout,
    output logic full,
    output logic empty
);

    localparam int PW = ptr_width(pDEPTH);
    localparam int AW = PW - 1;

    logic          mem [pDEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop && !empty)
                rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full && !reset)
            mem[wr_ptr[AW-1:0]] <= din;
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign dout  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/rx_frame_fifo.sv
// Store-and-forward RX frame FIFO: frames become readable only once committed,
// and errored / overflowing / slotless frames are discarded by rewinding the write pointer.
//   state  | meaning
//   IDLE   | no frame being presented; waits for a committed descriptor
//   STREAM | presenting beats of the head frame on the output register
module rx_frame_fifo
    import rx_fifo_pkg::*;
#(
    parameter int pDATA_W   = 8,
    parameter int pDEPTH    = 2048,
    parameter int pFRAMES   = 32,
    parameter int pDROP_ERR = 1
) (
    input  logic                       i_clk,
    input  logic                       ireset,
    input  logic                       ien,
    input  logic [pDATA_W-1:0]         iw_data,
    input  logic                       ilast,
    input  logic                       ierror,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [pDATA_W-1:0]         or_data,
    output logic                       o_last,
    output logic                       o_error,
    output logic [$clog2(pFRAMES):0]   o_frames,
    output logic [DROP_CNT_W-1:0]      o_drop_cnt
);

    localparam int PW = ptr_width(pDEPTH);
    localparam int AW = PW - 1;
    localparam int FW = $clog2(pFRAMES) + 1;

    logic [pDATA_W:0] mem [pDEPTH];
    logic [PW-1:0]    wr_ptr, wr_start, rd_ptr, used;
    logic             err_acc, ovf_acc;
    logic             mem_full, frame_err, drop, commit;
    logic             desc_full, desc_empty, desc_err;
    logic             load, pop, accept_last, next_pending;
    rd_state_t        state, state_next;

    assign used      = wr_ptr - rd_ptr;
    assign mem_full  = (used == PW'(pDEPTH));
    assign frame_err = err_acc | ierror;
    assign drop      = ien & ilast & (ovf_acc | mem_full | desc_full |
                                      ((pDROP_ERR != 0) & frame_err));
    assign commit    = ien & ilast & ~drop;

    always_ff @(posedge i_clk) begin
        if (ireset) begin
            wr_ptr     <= '0;
            wr_start   <= '0;
            err_acc    <= 1'b0;
            ovf_acc    <= 1'b0;
            o_drop_cnt <= '0;
        end else if (ien) begin
            if (ilast) begin
                err_acc <= 1'b0;
                ovf_acc <= 1'b0;
            end else begin
                err_acc <= frame_err;
                ovf_acc <= ovf_acc | mem_full;
            end
            if (drop) begin
                wr_ptr <= wr_start;
                if (o_drop_cnt != '1)
                    o_drop_cnt <= o_drop_cnt + DROP_CNT_W'(1);
            end else if (!mem_full) begin
                wr_ptr <= wr_ptr + PW'(1);
                if (ilast)
                    wr_start <= wr_ptr + PW'(1);
            end
        end
    end

    // Beats of a frame that is later dropped are written too; the rewind makes them dead.
    always_ff @(posedge i_clk) begin
        if (ien && !mem_full && !ireset)
            mem[wr_ptr[AW-1:0]] <= {ilast, iw_data};
    end

    sync_desc_fifo #(.pDEPTH(pFRAMES)) u_desc (
        .clk   (i_clk),
        .reset (ireset),
        .push  (commit),
        .pop   (pop),
        .din   (frame_err),
        .dout  (desc_err),
        .full  (desc_full),
        .empty (desc_empty)
    );

    assign accept_last  = o_valid & i_ready & o_last;
    assign next_pending = (o_frames > FW'(1));

    always_ff @(posedge i_clk) begin
        if (ireset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!desc_empty) begin
                    load       = 1'b1;
                    state_next = STREAM;
                end
            end
            STREAM: begin
                if (accept_last) begin
                    pop = 1'b1;
                    if (next_pending)
                        load = 1'b1;
                    else
                        state_next = IDLE;
                end else if (!o_valid || i_ready) begin
                    load = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (ireset) begin
            o_valid <= 1'b0;
            o_last  <= 1'b0;
            or_data <= '0;
            rd_ptr  <= '0;
        end else if (load) begin
            {o_last, or_data} <= mem[rd_ptr[AW-1:0]];
            o_valid           <= 1'b1;
            rd_ptr            <= rd_ptr + PW'(1);
        end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
            o_last  <= 1'b0;
        end
    end

    // Descriptor count mirrors committed-but-unread frames, so it also drives next_pending.
    always_ff @(posedge i_clk) begin
        if (ireset)
            o_frames <= '0;
        else if (commit && !pop)
            o_frames <= o_frames + FW'(1);
        else if (pop && !commit)
            o_frames <= o_frames - FW'(1);
    end

    assign o_error = o_last & desc_err;

endmodule

// File: doc/rx_frame_fifo.md
# rx_frame_fifo

Single-clock, parametrised store-and-forward frame FIFO for each switch RX port, sitting between the MAC RX byte stream and the forwarding/lookup stage. It buffers whole frames and releases a frame to the read side only after its last beat is committed. Frames that are errored (mode-dependent), overflow the buffer, or find no free frame slot are discarded atomically by rewinding the write pointer. Unlike the previous RX FIFO, it offers a ready/valid read handshake, frame boundaries, a frame count, and drop statistics.

## Interface
- pDATA_W, 8: data beat width in bits.
- pDEPTH, 2048: data buffer depth in beats; power of two, ≥ 64.
- pFRAMES, 32: maximum committed-but-unread frames; power of two.
- pDROP_ERR, 1: 1 = drop errored frames; 0 = forward them with o_error on the last beat.
- i_clk  in  1  single clock for both sides. One clock; reset is synchronous and active-high.
- ireset  in  1  synchronous, active-high reset.
- ien  in  1  write beat valid. There is no write backpressure.
- iw_data  in  pDATA_W  write beat.
- ilast  in  1  qualifies the final beat of a frame (valid only with ien).
- ierror  in  1  frame error flag; any beat with ierror=1 marks the whole frame.
- o_valid  out  1  read beat valid.
- i_ready  in  1  read side accepts the beat.
- or_data  out  pDATA_W  read beat.
- o_last  out  1  final beat of the frame.
- o_error  out  1  frame was errored (only when pDROP_ERR=0), qualified by o_last.
- o_frames  out  $clog2(pFRAMES)+1  committed frames not yet fully read.
- o_drop_cnt  out  16  saturating count of dropped frames.

## Operation
- Write side tracks rW_ptr (speculative) and rW_start (frame start). Pointers are $clog2(pDEPTH)+1 bits with an MSB wrap bit. Free space = pDEPTH − (rW_ptr − rR_ptr), computed modulo 2^(log2+1).
- Each beat is stored as {last, data} and rW_ptr increments. The sticky per-frame flags err_acc and ovf_acc clear on the first beat after ilast or after reset.
- Beat arriving with free space = 0: not stored, rW_ptr held, ovf_acc set.
- On the ilast beat, the frame is dropped if:
  - ovf_acc is set, or the beat itself overflows;
  - the descriptor FIFO is full;
  - pDROP_ERR=1 and (err_acc | ierror).
- Drop: rW_ptr ← rW_start and o_drop_cnt increments, saturating at 16'hFFFF.
- Commit: push {err_acc|ierror} into the descriptor FIFO and set rW_start ← rW_ptr+1.
- Read FSM:
  - IDLE: wait for descriptor FIFO non-empty, then go to STREAM.
  - STREAM: an output register loads from the memory at rR_ptr whenever o_valid=0 or i_ready=1. rR_ptr increments on each load.
  - When a beat with o_last=1 is accepted (o_valid & i_ready), pop the descriptor and return to IDLE, or stay in STREAM if another descriptor is pending.
  - o_error = descriptor error bit while o_last=1, else 0.
- o_frames increments on commit and decrements on last-beat acceptance; it is unchanged when both happen in the same cycle.
- The memory read is asynchronous (distributed RAM) so the output register loads directly.

## Timing
- Reset values: o_valid=0, o_last=0, o_error=0, or_data=0, o_frames=0, o_drop_cnt=0. All pointers are 0, the FSM is IDLE, and the accumulators are clear.
- Reset mid-frame discards the partial frame and all stored frames with no drop count; inputs in the reset cycle are ignored.
- Write-to-read latency: ilast written in cycle N → o_frames updates in N+1 → first beat o_valid=1 in N+2.
- Sustained read: one beat per cycle while i_ready=1. Back-to-back frames have no idle cycle between the o_last beat and the next frame's first beat.
- o_valid, when asserted, holds with stable data until accepted.
- A drop or rewind takes effect in the ilast cycle, and the next beat (N+1) writes at rW_start.
- Wrap-around: pointers wrap naturally, and a frame may span the buffer end.
- Frame length 1 (first beat carries ilast) is legal.
- Freed space from a read in cycle N is usable by the writer in N+1.

## Structure
- Package rx_fifo_pkg holds:
  - the read-FSM state enum {IDLE, STREAM};
  - the drop-counter width constant (16);
  - the helper function for pointer width.
- Sub-module sync_desc_fifo: a pFRAMES-deep, 1-bit-wide single-clock FIFO with push/pop/full/empty. It is reused later for frame-length descriptors.

## Test plan
- Single 64-beat frame (data 0..63), i_ready=1: o_valid rises 2 cycles after the ilast write, and 64 beats stream in order. o_last=1 on beat 63, o_error=0, o_frames returns 1→0.
- pDROP_ERR=1, 10-beat frame with ierror on beat 4, followed by a clean 5-beat frame: only the 5-beat frame appears and o_drop_cnt=1. Repeat with pDROP_ERR=0: both frames appear, with o_error=1 on the first frame's last beat.
- pDEPTH=64, i_ready=0, write a 70-beat frame: the frame is dropped, o_drop_cnt=1, and a following 10-beat frame is readable intact.
- Write pFRAMES+1 single-beat frames with i_ready=0: o_frames=pFRAMES and the last frame is dropped (o_drop_cnt=1).
- Random i_ready toggling over 200 frames that wrap the buffer several times: output equals the scoreboard, and or_data stays stable while o_valid=1 and i_ready=0.
- Assert ireset mid-frame with 2 frames stored: all outputs return to reset values next cycle, and a new 3-beat frame reads correctly.
